// File: rtl/reg_file_sb.sv
// ============================================================================
// Module   : reg_file_sb
// Purpose  : 2R/1W register file with a per-register pending-write scoreboard.
//            Optional write-to-read bypass enabled by macro REGFILE_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  BUSY1,
  output logic                  BUSY2,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  ISS_VALID,
  input  logic [ADDR_WIDTH-1:0] ISS_DEST,
  output logic                  ISS_RDY,
  input  logic                  FLUSH,
  output logic                  WB_ERR
);

  localparam int                   c_DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic                 c_ZERO    = (ZERO_REG != 0);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt [c_DEPTH];
  logic                  r_wb_err;

  logic                  w_iss_acc;
  logic                  w_iss_inc;
  logic                  w_wb_en;
  logic                  w_wb_err;
  logic [c_DEPTH-1:0]    w_inc_vec;
  logic [c_DEPTH-1:0]    w_dec_vec;

  // Register 0 never takes data or reservations when it is hardwired.
  assign ISS_RDY   = !RST || !(FLUSH || (r_cnt[ISS_DEST] == c_CNT_MAX));
  assign w_iss_acc = ISS_VALID && ISS_RDY && !FLUSH;
  assign w_iss_inc = w_iss_acc && !(c_ZERO && (ISS_DEST == '0));
  assign w_wb_en   = WE3 && !(c_ZERO && (A3 == '0));
  assign w_wb_err  = w_wb_en && !FLUSH && (r_cnt[A3] == '0);

  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    if (w_iss_inc) w_inc_vec[ISS_DEST] = 1'b1;
    if (w_wb_en)   w_dec_vec[A3]       = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wb_en) begin
      r_mem[A3] <= WD3;
    end
  end

  // An issue and a writeback to the same register cancel out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < c_DEPTH; i++) r_cnt[i] <= '0;
    end else if (FLUSH) begin
      for (int i = 0; i < c_DEPTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < c_DEPTH; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i])
          r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
        else if (!w_inc_vec[i] && w_dec_vec[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_wb_err <= 1'b0;
    else if (w_wb_err)
      r_wb_err <= 1'b1;
  end

  assign WB_ERR = r_wb_err;

  always_comb begin
    RD1   = r_mem[A1];
    RD2   = r_mem[A2];
    BUSY1 = (r_cnt[A1] != '0);
    BUSY2 = (r_cnt[A2] != '0);
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight writeback; its last reservation retires now.
    if (w_wb_en && (A3 == A1)) begin
      RD1 = WD3;
      if ((r_cnt[A1] == c_CNT_ONE) && !w_inc_vec[A3]) BUSY1 = 1'b0;
    end
    if (w_wb_en && (A3 == A2)) begin
      RD2 = WD3;
      if ((r_cnt[A2] == c_CNT_ONE) && !w_inc_vec[A3]) BUSY2 = 1'b0;
    end
`else
    // Read path sees only state, so writebacks appear one cycle later.
`endif
    if (c_ZERO && (A1 == '0)) begin
      RD1   = '0;
      BUSY1 = 1'b0;
    end
    if (c_ZERO && (A2 == '0)) begin
      RD2   = '0;
      BUSY2 = 1'b0;
    end
    if (!RST) begin
      RD1   = '0;
      RD2   = '0;
      BUSY1 = 1'b0;
      BUSY2 = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Directed self-checking bench for reg_file_sb (honours REGFILE_BYPASS_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  a1, a2, a3, iss_dest;
  logic [31:0] rd1, rd2, wd3;
  logic        busy1, busy2, we3, iss_valid, iss_rdy, flush, wb_err;

  int checks   = 0;
  int failures = 0;

  reg_file_sb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2), .ZERO_REG(1)
  ) u_dut (
    .CLK(clk), .RST(rst),
    .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2), .BUSY1(busy1), .BUSY2(busy2),
    .WE3(we3), .A3(a3), .WD3(wd3),
    .ISS_VALID(iss_valid), .ISS_DEST(iss_dest), .ISS_RDY(iss_rdy),
    .FLUSH(flush), .WB_ERR(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; a3 = '0; wd3 = '0;
    iss_valid = 1'b0; iss_dest = '0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    a1 = 5'd7; a2 = 5'd0;
    idle_inputs();
    // Write and flush during reset must be discarded and not disturb outputs
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hFFFF_0000; flush = 1'b1;
    #1;
    check("rst_rd1", rd1, 0);
    check("rst_iss_rdy", iss_rdy, 1);
    step(); step();
    idle_inputs();
    #1;
    check("rst_busy1", busy1, 0);
    check("rst_wb_err", wb_err, 0);
    rst = 1'b1;

    // Post-reset reads
    a1 = 5'd7; a2 = 5'd0;
    #1;
    check("idle_rd1", rd1, 0);
    check("idle_rd2", rd2, 0);
    check("idle_busy1", busy1, 0);
    check("idle_busy2", busy2, 0);
    check("idle_iss_rdy", iss_rdy, 1);

    // Issue to 5, then writeback DEADBEEF
    iss_valid = 1'b1; iss_dest = 5'd5; a1 = 5'd5;
    step();
    iss_valid = 1'b0;
    #1;
    check("r5_busy_after_issue", busy1, 1);
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r5_bypass_rd1", rd1, 32'hDEAD_BEEF);
    check("r5_bypass_busy1", busy1, 0);
`else
    check("r5_nobyp_rd1", rd1, 0);
    check("r5_nobyp_busy1", busy1, 1);
`endif
    step();
    we3 = 1'b0;
    #1;
    check("r5_rd1_next", rd1, 32'hDEAD_BEEF);
    check("r5_busy1_next", busy1, 0);
    check("r5_wb_err", wb_err, 0);

    // Saturate reg 9
    a1 = 5'd9; a2 = 5'd9;
    iss_valid = 1'b1; iss_dest = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("r9_rdy_before_full", iss_rdy, 1);
      step();
    end
    #1;
    check("r9_rdy_full", iss_rdy, 0);
    check("r9_busy_full", busy2, 1);
    step();                           // refused issue must not wrap the counter
    iss_valid = 1'b0;
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h0000_0009;
    step();
    we3 = 1'b0;
    #1;
    check("r9_rdy_after_wb1", iss_rdy, 1);
    check("r9_busy_after_wb1", busy1, 1);
    we3 = 1'b1;
    step();
    we3 = 1'b0;
    #1;
    check("r9_busy_after_wb2", busy1, 1);
    we3 = 1'b1;
    step();
    we3 = 1'b0;
    #1;
    check("r9_busy_after_wb3", busy1, 0);
    check("r9_rd2", rd2, 32'h0000_0009);
    check("r9_wb_err", wb_err, 0);

    // Simultaneous issue and writeback on reg 4
    a1 = 5'd4;
    iss_valid = 1'b1; iss_dest = 5'd4;
    step();
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'h0000_A5A5;
    #1;
    check("r4_busy_same_cycle", busy1, 1);
    step();
    idle_inputs();
    #1;
    check("r4_busy_after", busy1, 1);
    check("r4_rd1", rd1, 32'h0000_A5A5);
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'h0000_5A5A;
    step();
    we3 = 1'b0;
    #1;
    check("r4_busy_cleared", busy1, 0);
    check("r4_wb_err", wb_err, 0);

    // Writes to reg 0 and an unreserved writeback to reg 3
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h0000_1234;
    step();
    we3 = 1'b0; a1 = 5'd0;
    #1;
    check("r0_rd1", rd1, 0);
    check("r0_wb_err", wb_err, 0);
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_0077;
    step();
    we3 = 1'b0; a1 = 5'd3;
    #1;
    check("r3_wb_err_set", wb_err, 1);
    check("r3_rd1", rd1, 32'h0000_0077);
    step(); step();
    check("r3_wb_err_sticky", wb_err, 1);

    // Flush with a simultaneous issue
    iss_valid = 1'b1; iss_dest = 5'd2;
    step();
    iss_dest = 5'd3;
    step();
    iss_valid = 1'b0;
    a1 = 5'd2; a2 = 5'd3;
    #1;
    check("fl_busy_r2", busy1, 1);
    check("fl_busy_r3", busy2, 1);
    flush = 1'b1; iss_valid = 1'b1; iss_dest = 5'd6;
    #1;
    check("fl_iss_rdy", iss_rdy, 0);
    step();
    idle_inputs();
    #1;
    check("fl_busy_r2_clr", busy1, 0);
    check("fl_busy_r3_clr", busy2, 0);
    a1 = 5'd6; a2 = 5'd5;
    #1;
    check("fl_busy_r6", busy1, 0);
    check("fl_rd2_r5_kept", rd2, 32'hDEAD_BEEF);

    // Mid-operation reset
    iss_valid = 1'b1; iss_dest = 5'd7;
    step();
    iss_valid = 1'b0;
    a1 = 5'd3; a2 = 5'd7;
    #1;
    check("mr_busy_pre", busy2, 1);
    rst = 1'b0;
    #1;
    check("mr_rd1", rd1, 0);
    check("mr_busy2", busy2, 0);
    check("mr_wb_err", wb_err, 0);
    check("mr_iss_rdy", iss_rdy, 1);
    step();
    rst = 1'b1;
    iss_valid = 1'b1; iss_dest = 5'd8; a1 = 5'd8;
    step();
    iss_valid = 1'b0;
    #1;
    check("mr_resume_busy", busy1, 1);
    check("mr_resume_rd2", rd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
